// File: rtl/led_pkg.sv
// led_pkg: shared constants, duty type and driver FSM states for the LED PWM driver
package led_pkg;
  localparam int NUM_LEDS_MAX = 16;
  localparam int DUTY_BITS = 8;
  typedef logic [DUTY_BITS-1:0] duty_t;
  typedef enum logic {RUN, LOAD} drv_state_t;
endpackage

// File: rtl/led_pwm_timebase.sv
// led_pwm_timebase: clock prescaler and PWM frame counter; wrap marks the last tick of a frame
module led_pwm_timebase
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                tick,
  output logic                wrap,
  output logic [PWM_BITS-1:0] pwm_cnt
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  logic [PW-1:0] pre;
  assign tick = pre == PRE_MAX;
  assign wrap = tick && (&pwm_cnt);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pre     <= '0;
      pwm_cnt <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: 16-channel double-buffered PWM LED driver with valid/ready brightness port.
// Optional per-channel blink enabled by defining LED_BLINK_EN.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS = NUM_LEDS_MAX,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4
`ifdef LED_BLINK_EN
  ,
  parameter int BLINK_DIV = 6
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_all,
  input  logic [3:0]          cmd_idx,
  input  logic [PWM_BITS-1:0] cmd_duty,
`ifdef LED_BLINK_EN
  input  logic                cmd_blink,
`endif
  output logic [NUM_LEDS-1:0] led,
  output logic                frame_start
);
  logic [PWM_BITS-1:0] pending [NUM_LEDS];
  logic [PWM_BITS-1:0] active [NUM_LEDS];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] sel, dark;
  logic                wrap, unused_tick, dirty, hit, load;
  drv_state_t          state, state_nx;

  led_pwm_timebase #(.PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE)) u_tb (
    .clk(clk), .reset_n(reset_n), .tick(unused_tick), .wrap(wrap), .pwm_cnt(pwm_cnt)
  );

  // Out-of-range single-channel writes are swallowed without marking the bank dirty
  assign hit = cmd_valid && cmd_ready && (cmd_all || int'(cmd_idx) < NUM_LEDS);

  always_comb
    for (int i = 0; i < NUM_LEDS; i++) sel[i] = hit && (cmd_all || int'(cmd_idx) == i);

  // A write landing on the wrap cycle still triggers the reload that follows it
  always_comb begin
    load      = state == LOAD;
    cmd_ready = !load;
    state_nx  = load ? RUN : (wrap && (dirty || hit)) ? LOAD : RUN;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= RUN;
    else state <= state_nx;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dirty       <= 1'b0;
      frame_start <= 1'b0;
      led         <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      frame_start <= wrap;
      dirty       <= load ? 1'b0 : dirty | hit;
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (sel[i]) pending[i] <= cmd_duty;
        if (load) active[i] <= pending[i];
        led[i] <= enable && (pwm_cnt < active[i]) && !dark[i];
      end
    end

`ifdef LED_BLINK_EN
  logic [NUM_LEDS-1:0]  pend_blink, act_blink;
  logic [BLINK_DIV-1:0] frame_cnt;
  logic                 blink_phase;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend_blink  <= '0;
      act_blink   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (wrap) frame_cnt <= frame_cnt + 1'b1;
      if (wrap && (&frame_cnt)) blink_phase <= !blink_phase;
      if (load) act_blink <= pend_blink;
      for (int i = 0; i < NUM_LEDS; i++)
        if (sel[i]) pend_blink[i] <= cmd_blink;
    end

  assign dark = act_blink & {NUM_LEDS{!blink_phase}};
`else
  assign dark = '0;
`endif
endmodule
